// File: rtl/refill_pkg.sv
// Shared types and sizing helpers for the L1 refill arbiter and its round-robin grant logic.
package refill_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DATA = 2'd2,
      DONE = 2'd3
   } refill_state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } requester_t;

   localparam int PERF_CNT_W = 32;

   // Number of byte-offset bits inside one cache block.
   function automatic int offset_width(input int block_words, input int data_w);
      return $clog2(block_words * data_w / 8);
   endfunction

   function automatic int word_idx_width(input int block_words);
      return $clog2(block_words);
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant between the I-side and D-side refill requesters.
module rr_arbiter2
   import refill_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       req_i,
   input  logic       req_d,
   input  logic       update,
   input  requester_t update_id,
   output logic       grant_valid,
   output requester_t grant_id
);

   requester_t last_grant;

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= REQ_I;
      end else if (update) begin
         last_grant <= update_id;
      end
   end

   // When both sides ask, the side that was not served last wins.
   always_comb begin
      grant_valid = req_i || req_d;
      grant_id    = REQ_I;
      if (req_i && req_d) begin
         grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
      end else if (req_d) begin
         grant_id = REQ_D;
      end
   end

endmodule

// File: rtl/refill_arbiter.sv
// Shares one external memory burst-read port between I-cache and D-cache block refills.
// Optional macro REFILL_PERF_CNT_EN adds the IRefillCount and DStallCycles counter ports.
module refill_arbiter
   import refill_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int BLOCK_WORDS = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           IReqValid,
   input  logic [ADDR_W-1:0]              IReqAddr,
   input  logic                           IAbort,
   input  logic                           DReqValid,
   input  logic [ADDR_W-1:0]              DReqAddr,
   output logic                           MemReqValid,
   input  logic                           MemReqReady,
   output logic [ADDR_W-1:0]              MemReqAddr,
   input  logic                           MemRespValid,
   input  logic [DATA_W-1:0]              MemRespData,
   output logic [DATA_W-1:0]              RefillData,
   output logic [$clog2(BLOCK_WORDS)-1:0] RefillWordIdx,
   output logic                           IRefillValid,
   output logic                           DRefillValid,
   output logic                           IRefillDone,
   output logic                           DRefillDone,
   output logic                           Busy
`ifdef REFILL_PERF_CNT_EN
   ,
   output logic [PERF_CNT_W-1:0]          IRefillCount,
   output logic [PERF_CNT_W-1:0]          DStallCycles
`endif
);

   localparam int                IDX_W      = word_idx_width(BLOCK_WORDS);
   localparam int                OFF_W      = offset_width(BLOCK_WORDS, DATA_W);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFF_W;
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);

   refill_state_t     state;
   requester_t        gnt;
   logic              abort_q;
   logic [IDX_W-1:0]  beat_cnt;

   logic              arb_valid;
   requester_t        arb_id;
   logic              i_abort_hit;
   logic              i_suppress;
   logic              last_beat;

   rr_arbiter2 u_arb (
      .clk         (clk),
      .reset       (reset),
      .req_i       (IReqValid && !IAbort),
      .req_d       (DReqValid),
      .update      (state == DONE),
      .update_id   (gnt),
      .grant_valid (arb_valid),
      .grant_id    (arb_id)
   );

   // An abort in the same cycle as a beat already hides that beat from the I-cache.
   assign i_abort_hit = IAbort && (gnt == REQ_I);
   assign i_suppress  = abort_q || i_abort_hit;
   assign last_beat   = (beat_cnt == LAST_IDX);
   assign Busy        = (state != IDLE);

   // NOTE: every register below is assigned with <= so all state updates see pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         gnt           <= REQ_I;
         abort_q       <= 1'b0;
         beat_cnt      <= '0;
         MemReqValid   <= 1'b0;
         MemReqAddr    <= '0;
         RefillData    <= '0;
         RefillWordIdx <= '0;
         IRefillValid  <= 1'b0;
         DRefillValid  <= 1'b0;
         IRefillDone   <= 1'b0;
         DRefillDone   <= 1'b0;
      end else begin
         IRefillValid <= 1'b0;
         DRefillValid <= 1'b0;
         IRefillDone  <= 1'b0;
         DRefillDone  <= 1'b0;

         case (state)
            IDLE: begin
               if (arb_valid) begin
                  gnt         <= arb_id;
                  MemReqAddr  <= ((arb_id == REQ_I) ? IReqAddr : DReqAddr) & ALIGN_MASK;
                  MemReqValid <= 1'b1;
                  state       <= REQ;
               end
            end

            // The request is never withdrawn; an abort only marks the burst to be drained.
            REQ: begin
               if (i_abort_hit) begin
                  abort_q <= 1'b1;
               end
               if (MemReqReady) begin
                  MemReqValid <= 1'b0;
                  beat_cnt    <= '0;
                  state       <= DATA;
               end
            end

            DATA: begin
               if (i_abort_hit) begin
                  abort_q <= 1'b1;
               end
               if (MemRespValid) begin
                  RefillData    <= MemRespData;
                  RefillWordIdx <= beat_cnt;
                  beat_cnt      <= beat_cnt + IDX_W'(1);
                  if (gnt == REQ_I) begin
                     IRefillValid <= !i_suppress;
                  end else begin
                     DRefillValid <= 1'b1;
                  end
                  if (last_beat) begin
                     state <= DONE;
                     if (gnt == REQ_I) begin
                        IRefillDone <= !i_suppress;
                     end else begin
                        DRefillDone <= 1'b1;
                     end
                  end
               end
            end

            DONE: begin
               abort_q <= 1'b0;
               state   <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef REFILL_PERF_CNT_EN
   // Saturating counters; a D stall is any cycle D asks while not being served.
   always_ff @(posedge clk) begin
      if (reset) begin
         IRefillCount <= '0;
         DStallCycles <= '0;
      end else begin
         if (IRefillDone && (IRefillCount != '1)) begin
            IRefillCount <= IRefillCount + PERF_CNT_W'(1);
         end
         if (DReqValid && !((state != IDLE) && (gnt == REQ_D)) && (DStallCycles != '1)) begin
            DStallCycles <= DStallCycles + PERF_CNT_W'(1);
         end
      end
   end
`endif

endmodule
